// File: rtl/blockmem_pkg.sv
// Shared types and sizing helpers for the block-memory array-side sequencer.
package blockmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

    localparam int MESHUNITS_DEF = 4;
    localparam int TILEUNITS_DEF = 4;
    localparam int TILE_SHIFT    = $clog2(TILEUNITS_DEF);
    localparam int BLOCK_SIZE    = MESHUNITS_DEF * MESHUNITS_DEF * TILEUNITS_DEF * TILEUNITS_DEF;

    // Shift that turns an element index into a tile-row address stride.
    function automatic int tile_shift(input int tileunits);
        return $clog2(tileunits);
    endfunction

endpackage

// File: rtl/blockmem_sched_skew_addr_gen.sv
// Skewed per-row strobe/address generator: row i is active for phase counts i..i+TILEUNITS-1.
module skew_addr_gen
    import blockmem_pkg::*;
#(
    parameter int BITWIDTH  = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 4,
    parameter int CW        = 5
) (
    input  logic [BITWIDTH-1:0]                 base,
    input  logic [CW-1:0]                       c,
    input  logic                                enable,
    output logic [MESHUNITS-1:0]                valid,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]  addr
);

    localparam int TS = tile_shift(TILEUNITS);

    generate
        for (genvar gi = 0; gi < MESHUNITS; gi++) begin : g_row
            logic [CW:0]          k_ext;
            logic                 in_window;
            logic [BITWIDTH-1:0]  offset;

            // Extra bit of k_ext flags c < gi (row not started yet).
            assign k_ext     = {1'b0, c} - (CW+1)'(gi);
            assign in_window = enable && !k_ext[CW] && (k_ext[CW-1:0] < CW'(TILEUNITS));
            assign offset    = (BITWIDTH'(gi * TILEUNITS) + BITWIDTH'(k_ext[CW-1:0])) << TS;
            assign valid[gi] = in_window;
            assign addr[gi]  = in_window ? base + offset : '0;
        end
    endgenerate

endmodule

// File: rtl/blockmem_sched.sv
// Array-side sequencer for one tile matmul pass: skewed A/D/B reads, fixed latency, skewed C writes.
module blockmem_sched
    import blockmem_pkg::*;
#(
    parameter int BITWIDTH  = 16,
    parameter int MESHUNITS = 4,
    parameter int TILEUNITS = 4,
    parameter int LAT       = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [BITWIDTH-1:0]                 A_base,
    input  logic [BITWIDTH-1:0]                 D_base,
    input  logic [BITWIDTH-1:0]                 B_base,
    input  logic [BITWIDTH-1:0]                 C_base,
    output logic                                busy,
    output logic                                done,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]  A_tile_read_addrs,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]  D_tile_read_addrs,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]  B_tile_read_addrs,
    output logic [MESHUNITS-1:0]                A_read_valid,
    output logic [MESHUNITS-1:0]                D_read_valid,
    output logic [MESHUNITS-1:0]                B_read_valid,
    output logic [MESHUNITS-1:0][BITWIDTH-1:0]  C_tile_write_addrs,
    output logic [MESHUNITS-1:0]                C_write_valid,
    input  logic                                loader_req,
    output logic                                loader_grant,
    output logic                                loader_write_valid
);

    localparam int CW = $clog2(MESHUNITS + TILEUNITS + LAT) + 1;
    localparam logic [CW-1:0]       PHASE_LAST = CW'(MESHUNITS + TILEUNITS - 2);
    localparam logic [CW-1:0]       WAIT_LAST  = CW'(LAT - 1);
    localparam logic [BITWIDTH-1:0] ALIGN_MASK = ~BITWIDTH'(TILEUNITS - 1);

    sched_state_t         state_reg, state_next;
    logic [CW-1:0]        c_reg, c_next;
    logic [BITWIDTH-1:0]  a_base_reg, d_base_reg, b_base_reg, c_base_reg;
    logic [BITWIDTH-1:0]  a_base_next, d_base_next, b_base_next, c_base_next;

    logic                                busy_next, done_next, rd_en_next, wr_en_next;
    logic [MESHUNITS-1:0]                rd_valid_next, wr_valid_next;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]  rd_off_next, wr_addr_next;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]  a_addr_next, d_addr_next, b_addr_next;

    logic                                busy_reg, done_reg;
    logic [MESHUNITS-1:0]                rd_valid_reg, wr_valid_reg;
    logic [MESHUNITS-1:0][BITWIDTH-1:0]  a_addr_reg, d_addr_reg, b_addr_reg, wr_addr_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            c_reg      <= '0;
            a_base_reg <= '0;
            d_base_reg <= '0;
            b_base_reg <= '0;
            c_base_reg <= '0;
        end else begin
            state_reg  <= state_next;
            c_reg      <= c_next;
            a_base_reg <= a_base_next;
            d_base_reg <= d_base_next;
            b_base_reg <= b_base_next;
            c_base_reg <= c_base_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        c_next      = c_reg;
        a_base_next = a_base_reg;
        d_base_next = d_base_reg;
        b_base_next = b_base_reg;
        c_base_next = c_base_reg;
        case (state_reg)
            IDLE: if (start) begin
                state_next  = READ;
                c_next      = '0;
                a_base_next = A_base & ALIGN_MASK;
                d_base_next = D_base & ALIGN_MASK;
                b_base_next = B_base & ALIGN_MASK;
                c_base_next = C_base & ALIGN_MASK;
            end
            READ: begin
                state_next = (c_reg == PHASE_LAST) ? WAIT : READ;
                c_next     = (c_reg == PHASE_LAST) ? '0 : c_reg + 1'b1;
            end
            WAIT: begin
                state_next = (c_reg == WAIT_LAST) ? WRITE : WAIT;
                c_next     = (c_reg == WAIT_LAST) ? '0 : c_reg + 1'b1;
            end
            WRITE: begin
                state_next = (c_reg == PHASE_LAST) ? DONE : WRITE;
                c_next     = (c_reg == PHASE_LAST) ? '0 : c_reg + 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                c_next     = '0;
            end
            default: begin
                state_next = IDLE;
                c_next     = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copy lines up with the state.
    always_comb begin
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        rd_en_next = (state_next == READ);
        wr_en_next = (state_next == WRITE);
    end

    skew_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .CW       (CW)
    ) u_read_gen (
        .base  ('0),
        .c     (c_next),
        .enable(rd_en_next),
        .valid (rd_valid_next),
        .addr  (rd_off_next)
    );

    skew_addr_gen #(
        .BITWIDTH (BITWIDTH),
        .MESHUNITS(MESHUNITS),
        .TILEUNITS(TILEUNITS),
        .CW       (CW)
    ) u_write_gen (
        .base  (c_base_next),
        .c     (c_next),
        .enable(wr_en_next),
        .valid (wr_valid_next),
        .addr  (wr_addr_next)
    );

    // A/D/B share one skew pattern; only the base differs per operand.
    generate
        for (genvar gi = 0; gi < MESHUNITS; gi++) begin : g_rd_addr
            assign a_addr_next[gi] = rd_valid_next[gi] ? a_base_next + rd_off_next[gi] : '0;
            assign d_addr_next[gi] = rd_valid_next[gi] ? d_base_next + rd_off_next[gi] : '0;
            assign b_addr_next[gi] = rd_valid_next[gi] ? b_base_next + rd_off_next[gi] : '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= '0;
            wr_valid_reg <= '0;
            a_addr_reg   <= '0;
            d_addr_reg   <= '0;
            b_addr_reg   <= '0;
            wr_addr_reg  <= '0;
        end else begin
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rd_valid_reg <= rd_valid_next;
            wr_valid_reg <= wr_valid_next;
            a_addr_reg   <= a_addr_next;
            d_addr_reg   <= d_addr_next;
            b_addr_reg   <= b_addr_next;
            wr_addr_reg  <= wr_addr_next;
        end
    end

    assign busy               = busy_reg;
    assign done               = done_reg;
    assign A_read_valid       = rd_valid_reg;
    assign D_read_valid       = rd_valid_reg;
    assign B_read_valid       = rd_valid_reg;
    assign A_tile_read_addrs  = a_addr_reg;
    assign D_tile_read_addrs  = d_addr_reg;
    assign B_tile_read_addrs  = b_addr_reg;
    assign C_write_valid      = wr_valid_reg;
    assign C_tile_write_addrs = wr_addr_reg;

    // Start has priority over the loader so a pass never begins under a loader write.
    assign loader_grant       = (state_reg == IDLE) && !start && !reset;
    assign loader_write_valid = loader_req && loader_grant;

endmodule
